// File: rtl/wb_mem_arbiter.sv
// Two-master pipelined Wishbone arbiter sharing one single-port synchronous RAM.
// Round-robin on conflicts; a {valid, id} tag pipeline steers each ack back to its issuer.
module wb_mem_arbiter #(
    parameter int AW  = 15,
    parameter int LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [3:0]    i_sel,
    input  logic [31:0]   i_adr,
    input  logic [31:0]   i_dat_m,
    output logic          i_ack,
    output logic          i_stall,
    output logic [31:0]   i_dat_s,

    input  logic          d_cyc,
    input  logic          d_stb,
    input  logic          d_we,
    input  logic [3:0]    d_sel,
    input  logic [31:0]   d_adr,
    input  logic [31:0]   d_dat_m,
    output logic          d_ack,
    output logic          d_stall,
    output logic [31:0]   d_dat_s,

    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_d,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_q
);

    localparam logic INS = 1'b0;
    localparam logic DAT = 1'b1;

    logic           i_req;
    logic           d_req;
    logic           grant_i;
    logic           grant_d;
    logic           granted;
    logic           grant_id;
    logic           last;
    logic [LAT-1:0] stg_valid;
    logic [LAT-1:0] stg_id;
    logic           unused_adr_bits;

    assign i_req = i_cyc & i_stb;
    assign d_req = d_cyc & d_stb;

    // Nothing is granted while reset is held, so both stalls simply follow the requests.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst_i) begin
            if (i_req && d_req) begin
                if (last == INS) grant_d = 1'b1;
                else             grant_i = 1'b1;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    assign granted  = grant_i | grant_d;
    assign grant_id = grant_d ? DAT : INS;

    assign i_stall = i_req & ~grant_i;
    assign d_stall = d_req & ~grant_d;

    // The instruction master owns the memory bus whenever the data master is not granted.
    always_comb begin
        mem_adr = i_adr[AW+1:2];
        mem_d   = i_dat_m;
        mem_be  = i_sel;
        mem_we  = grant_i & i_we;
        if (grant_d) begin
            mem_adr = d_adr[AW+1:2];
            mem_d   = d_dat_m;
            mem_be  = d_sel;
            mem_we  = d_we;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last <= INS;
        end else if (granted) begin
            last <= grant_id;
        end
    end

    // Entries whose owner has dropped cyc are killed as they advance; the last
    // stage is covered by the cyc term in the ack equations below.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_valid <= '0;
            stg_id    <= '0;
        end else begin
            stg_valid[0] <= granted;
            stg_id[0]    <= grant_id;
            for (int k = 1; k < LAT; k++) begin
                stg_valid[k] <= stg_valid[k-1] & (stg_id[k-1] ? d_cyc : i_cyc);
                stg_id[k]    <= stg_id[k-1];
            end
        end
    end

    assign i_ack = stg_valid[LAT-1] & (stg_id[LAT-1] == INS) & i_cyc;
    assign d_ack = stg_valid[LAT-1] & (stg_id[LAT-1] == DAT) & d_cyc;

    assign i_dat_s = mem_q;
    assign d_dat_s = mem_q;

    assign unused_adr_bits = ^{i_adr[31:AW+2], i_adr[1:0], d_adr[31:AW+2], d_adr[1:0]};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: RAM stub, reference model with an ack scoreboard,
// a vector table for arbitration, directed corner sequences and random traffic.
module tb_wb_mem_arbiter;

    localparam int AW  = 15;
    localparam int LAT = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_cyc, i_stb, i_we;
    logic [3:0]    i_sel;
    logic [31:0]   i_adr, i_dat_m, i_dat_s;
    logic          i_ack, i_stall;
    logic          d_cyc, d_stb, d_we;
    logic [3:0]    d_sel;
    logic [31:0]   d_adr, d_dat_m, d_dat_s;
    logic          d_ack, d_stall;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_d;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_q;

    wb_mem_arbiter #(.AW(AW), .LAT(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_adr(i_adr),
        .i_dat_m(i_dat_m), .i_ack(i_ack), .i_stall(i_stall), .i_dat_s(i_dat_s),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr),
        .d_dat_m(d_dat_m), .d_ack(d_ack), .d_stall(d_stall), .d_dat_s(d_dat_s),
        .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_be(mem_be), .mem_q(mem_q)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- write-first RAM stub, LAT clocks of read latency ----------------
    logic [31:0] ram [0:2**AW-1];
    logic [31:0] rd_pipe [LAT];
    logic [31:0] ram_w;
    logic        ld_en;
    logic [6:0]  ld_adr;
    logic [31:0] ld_dat;

    always_comb begin
        ram_w = ram[mem_adr];
        for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram_w[8*b +: 8] = mem_d[8*b +: 8];
    end

    always @(posedge clk_i) begin
        if (ld_en)       ram[{8'd0, ld_adr}] <= ld_dat;
        else if (mem_we) ram[mem_adr] <= ram_w;
        rd_pipe[0] <= mem_we ? ram_w : ram[mem_adr];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_q = rd_pipe[LAT-1];

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] model_mem [0:127];
    logic [31:0] exp_q [$];
    int          exp_due [$];
    logic        exp_id [$];
    logic        exp_rd [$];
    logic        m_last;
    int          cyc_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_cnt);
        end
    endtask

    // Rules: lone requester wins; on a tie the master that did not win the
    // previous grant wins; an ack appears LAT cycles after its grant unless the
    // owner had cyc low in any cycle since.
    task automatic model_cycle();
        logic ri, rd, gi, gd, g, we_x, ia, da;
        logic [31:0] ea, w, dat;
        logic [3:0]  sel;
        ri = i_cyc & i_stb;
        rd = d_cyc & d_stb;
        gi = 1'b0;
        gd = 1'b0;
        if (rst_i) begin
            exp_q.delete(); exp_due.delete(); exp_id.delete(); exp_rd.delete();
            m_last = 1'b0;
        end else if (ri && rd) begin
            gd = (m_last == 1'b0);
            gi = ~gd;
        end else begin
            gi = ri;
            gd = rd;
        end
        chk("i_stall", {31'd0, i_stall}, {31'd0, ri & ~gi});
        chk("d_stall", {31'd0, d_stall}, {31'd0, rd & ~gd});
        g    = gi | gd;
        we_x = g & (gd ? d_we : i_we);
        ea   = ((gd ? d_adr : i_adr) >> 2) & 32'h7FFF;
        sel  = gd ? d_sel : i_sel;
        dat  = gd ? d_dat_m : i_dat_m;
        chk("mem_we", {31'd0, mem_we}, {31'd0, we_x});
        if (g) begin
            chk("mem_adr", {17'd0, mem_adr}, ea);
            chk("mem_be", {28'd0, mem_be}, {28'd0, sel});
            if (we_x) chk("mem_d", mem_d, dat);
        end
        ia = 1'b0;
        da = 1'b0;
        if (exp_due.size() > 0 && exp_due[0] == cyc_cnt) begin
            ia = (exp_id[0] == 1'b0) & i_cyc;
            da = (exp_id[0] == 1'b1) & d_cyc;
            if (ia && exp_rd[0]) chk("i_dat_s", i_dat_s, exp_q[0]);
            if (da && exp_rd[0]) chk("d_dat_s", d_dat_s, exp_q[0]);
            void'(exp_q.pop_front()); void'(exp_due.pop_front());
            void'(exp_id.pop_front()); void'(exp_rd.pop_front());
        end
        chk("i_ack", {31'd0, i_ack}, {31'd0, ia});
        chk("d_ack", {31'd0, d_ack}, {31'd0, da});
        for (int k = exp_due.size() - 1; k >= 0; k--) begin
            if ((exp_id[k] == 1'b0 && !i_cyc) || (exp_id[k] == 1'b1 && !d_cyc)) begin
                exp_q.delete(k); exp_due.delete(k); exp_id.delete(k); exp_rd.delete(k);
            end
        end
        if (g) begin
            if (we_x) begin
                w = model_mem[ea[6:0]];
                for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
                model_mem[ea[6:0]] = w;
            end
            exp_q.push_back(model_mem[ea[6:0]]);
            exp_due.push_back(cyc_cnt + LAT);
            exp_id.push_back(gd);
            exp_rd.push_back(~we_x);
            m_last = gd;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        #1;
        model_cycle();
        @(posedge clk_i);
        #1;
        cyc_cnt++;
    endtask

    task automatic idle(input logic ic, input logic dc);
        i_cyc = ic; i_stb = 1'b0; i_we = 1'b0; i_sel = 4'hF; i_adr = '0; i_dat_m = '0;
        d_cyc = dc; d_stb = 1'b0; d_we = 1'b0; d_sel = 4'hF; d_adr = '0; d_dat_m = '0;
    endtask

    task automatic drv_i(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        i_cyc = 1'b1; i_stb = 1'b1; i_we = we; i_adr = adr; i_sel = sel; i_dat_m = dat;
    endtask

    task automatic drv_d(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_adr = adr; d_sel = sel; d_dat_m = dat;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        idle(1'b0, 1'b0);
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ir, dr, iw, dw;
        logic e_is, e_ds, e_we, e_ia, e_da;
    } vec_t;
    vec_t tbl [14];

    // ---------------- test sequence ----------------
    initial begin
        cyc_cnt = 0;
        m_last  = 1'b0;
        rst_i   = 1'b1;
        idle(1'b0, 1'b0);
        ld_en   = 1'b1;
        for (int a = 0; a < 128; a++) begin
            ld_adr = a[6:0];
            ld_dat = (a == 64) ? 32'h12345678 : (a == 2) ? 32'h11111111 : $urandom;
            model_mem[a] = ld_dat;
            @(posedge clk_i);
            #1;
        end
        ld_en = 1'b0;

        // reset values: stall follows request, no acks, no write
        drv_i(1'b0, 32'h0, 4'hF, 32'h0);
        #1;
        chk("rst_i_stall", {31'd0, i_stall}, 32'd1);
        chk("rst_d_stall", {31'd0, d_stall}, 32'd0);
        chk("rst_i_ack", {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        step();
        do_reset(2);

        // arbitration table, applied straight out of reset
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 14; k++) begin
            idle(1'b1, 1'b1);
            i_stb = tbl[k].ir; i_we = tbl[k].iw; i_adr = 32'h10; i_dat_m = 32'hA5A5A5A5;
            d_stb = tbl[k].dr; d_we = tbl[k].dw; d_adr = 32'h14; d_dat_m = 32'h5A5A5A5A;
            #1;
            chk($sformatf("tbl%0d_i_stall", k), {31'd0, i_stall}, {31'd0, tbl[k].e_is});
            chk($sformatf("tbl%0d_d_stall", k), {31'd0, d_stall}, {31'd0, tbl[k].e_ds});
            chk($sformatf("tbl%0d_mem_we", k), {31'd0, mem_we}, {31'd0, tbl[k].e_we});
            chk($sformatf("tbl%0d_i_ack", k), {31'd0, i_ack}, {31'd0, tbl[k].e_ia});
            chk($sformatf("tbl%0d_d_ack", k), {31'd0, d_ack}, {31'd0, tbl[k].e_da});
            step();
        end

        // lone instruction read of word 0x40
        idle(1'b1, 1'b0);
        drv_i(1'b0, 32'h100, 4'hF, 32'h0);
        #1;
        chk("rd_i_stall", {31'd0, i_stall}, 32'd0);
        chk("rd_mem_adr", {17'd0, mem_adr}, 32'h40);
        step();
        idle(1'b1, 1'b0);
        #1;
        chk("rd_i_ack_early", {31'd0, i_ack}, 32'd0);
        step();
        #1;
        chk("rd_i_ack", {31'd0, i_ack}, 32'd1);
        chk("rd_i_dat", i_dat_s, 32'h12345678);
        chk("rd_d_ack", {31'd0, d_ack}, 32'd0);
        step();
        #1;
        chk("rd_i_ack_late", {31'd0, i_ack}, 32'd0);
        step();

        // partial write into word 2, then read back
        idle(1'b0, 1'b1);
        drv_d(1'b1, 32'h8, 4'b0011, 32'hDEADBEEF);
        #1;
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_be", {28'd0, mem_be}, 32'h3);
        step();
        idle(1'b0, 1'b1);
        step();
        drv_d(1'b0, 32'h8, 4'hF, 32'h0);
        #1;
        chk("wr_d_ack", {31'd0, d_ack}, 32'd1);
        step();
        idle(1'b0, 1'b1);
        step();
        #1;
        chk("wr_rb_ack", {31'd0, d_ack}, 32'd1);
        chk("wr_rb_dat", d_dat_s, 32'h1111BEEF);
        step();

        // instruction abort while a data read is in flight
        idle(1'b1, 1'b1);
        drv_i(1'b0, 32'h0, 4'hF, 32'h0);
        step();
        idle(1'b0, 1'b1);
        drv_d(1'b0, 32'h4, 4'hF, 32'h0);
        step();
        idle(1'b1, 1'b1);
        #1;
        chk("ab_i_ack_due", {31'd0, i_ack}, 32'd0);
        step();
        #1;
        chk("ab_d_ack", {31'd0, d_ack}, 32'd1);
        chk("ab_i_ack_after", {31'd0, i_ack}, 32'd0);
        step();
        step();

        // four back-to-back data reads
        for (int k = 0; k < 6; k++) begin
            idle(1'b0, 1'b1);
            if (k < 4) drv_d(1'b0, 32'(4 * k), 4'hF, 32'h0);
            #1;
            chk($sformatf("burst%0d_d_stall", k), {31'd0, d_stall}, 32'd0);
            if (k >= 2) begin
                chk($sformatf("burst%0d_d_ack", k), {31'd0, d_ack}, 32'd1);
                chk($sformatf("burst%0d_d_dat", k), d_dat_s, model_mem[k-2]);
            end
            step();
        end
        #1;
        chk("burst_end_ack", {31'd0, d_ack}, 32'd0);
        step();

        // reset with two accesses in flight
        idle(1'b1, 1'b1);
        drv_i(1'b0, 32'h20, 4'hF, 32'h0);
        drv_d(1'b0, 32'h24, 4'hF, 32'h0);
        step();
        step();
        rst_i = 1'b1;
        idle(1'b1, 1'b1);
        #1;
        chk("mr_i_ack", {31'd0, i_ack}, 32'd0);
        chk("mr_d_ack", {31'd0, d_ack}, 32'd0);
        step();
        step();
        rst_i = 1'b0;
        drv_i(1'b0, 32'h20, 4'hF, 32'h0);
        drv_d(1'b0, 32'h24, 4'hF, 32'h0);
        #1;
        chk("mr_d_first", {31'd0, d_stall}, 32'd0);
        chk("mr_i_stall", {31'd0, i_stall}, 32'd1);
        chk("mr_no_i_ack", {31'd0, i_ack}, 32'd0);
        chk("mr_no_d_ack", {31'd0, d_ack}, 32'd0);
        step();
        idle(1'b1, 1'b1);
        repeat (3) step();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic ic, dc;
            ic = i_cyc;
            dc = d_cyc;
            if ($urandom_range(0, 7) == 0) ic = ~ic;
            if ($urandom_range(0, 7) == 0) dc = ~dc;
            idle(ic, dc);
            if (ic && $urandom_range(0, 2) != 0)
                drv_i(1'($urandom_range(0, 3) == 0),
                      ($urandom & 32'hFFFE0000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), $urandom);
            if (dc && $urandom_range(0, 2) != 0)
                drv_d(1'($urandom_range(0, 2) == 0),
                      ($urandom & 32'hFFFE0000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), $urandom);
            step();
        end
        idle(1'b1, 1'b1);
        repeat (LAT + 1) step();
        chk("sb_drained", 32'(exp_due.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
